// File: rtl/fifo_deframe.sv
// fifo_deframe
//   Splits a framed word stream coming out of one first-word-fall-through FIFO
//   into two client sink FIFOs. Each frame is one header word followed by
//   1..2^popcount(CNTMASK) payload words. Header bits under SELMASK pick the
//   client (non-zero -> client 2); the contiguous CNTMASK field holds the
//   payload length minus one. Data passes straight through with no register
//   stage, so a word is written to its sink in the same cycle it is popped.
//
// Ports
//   CLK, RESET              : clock, synchronous active-high reset
//   in_rden                 : pop strobe to the source FIFO
//   in_rdempty, in_rddata   : source status and head-of-FIFO data
//   c1_wren, c1_wrfull,
//   c1_wrdata               : client 1 sink write port
//   c2_wren, c2_wrfull,
//   c2_wrdata               : client 2 sink write port
//   busy                    : high while a frame's payload is being moved
//   c1_frames, c2_frames    : saturating counts of completed frames per client
module fifo_deframe #(
  parameter int              DW      = 8,
  parameter logic [DW-1:0]   SELMASK = 8'h80,
  parameter logic [DW-1:0]   CNTMASK = 8'h70
) (
  input  logic          CLK,
  input  logic          RESET,
  output logic          in_rden,
  input  logic          in_rdempty,
  input  logic [DW-1:0] in_rddata,
  output logic          c1_wren,
  input  logic          c1_wrfull,
  output logic [DW-1:0] c1_wrdata,
  output logic          c2_wren,
  input  logic          c2_wrfull,
  output logic [DW-1:0] c2_wrdata,
  output logic          busy,
  output logic [15:0]   c1_frames,
  output logic [15:0]   c2_frames
);

  function automatic int mask_lsb(input logic [DW-1:0] m);
    int pos;
    pos = 0;
    for (int i = DW - 1; i >= 0; i--) begin
      if (m[i]) pos = i;
    end
    return pos;
  endfunction

  function automatic int mask_pop(input logic [DW-1:0] m);
    int n;
    n = 0;
    for (int i = 0; i < DW; i++) begin
      if (m[i]) n = n + 1;
    end
    return n;
  endfunction

  localparam int CNT_LSB  = mask_lsb(CNTMASK);
  localparam int CNT_BITS = mask_pop(CNTMASK);
  // One extra bit so that "field all ones" plus one still fits.
  localparam int REM_W    = CNT_BITS + 1;

  typedef enum logic {
    HDR,
    PAYLOAD
  } state_t;

  state_t             state;
  state_t             next_state;
  logic               sel;
  logic [REM_W-1:0]   remaining;
  logic [REM_W-1:0]   hdr_field;
  logic [REM_W-1:0]   hdr_len;
  logic               hdr_sel;
  logic               sel_full;
  logic               hdr_pop;
  logic               xfer;
  logic               last_xfer;

  assign c1_wrdata = in_rddata;
  assign c2_wrdata = in_rddata;

  // Pull the length field out bit by bit so any contiguous CNTMASK works.
  always_comb begin
    hdr_field = '0;
    for (int i = 0; i < CNT_BITS; i++) begin
      hdr_field[i] = in_rddata[CNT_LSB + i];
    end
  end

  assign hdr_len   = hdr_field + REM_W'(1);
  assign hdr_sel   = |(in_rddata & SELMASK);
  // Only the selected client's full flag may stall the frame.
  assign sel_full  = sel ? c2_wrfull : c1_wrfull;
  assign last_xfer = xfer && (remaining == REM_W'(1));

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= HDR;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      HDR:     if (hdr_pop)   next_state = PAYLOAD;
      PAYLOAD: if (last_xfer) next_state = HDR;
      default: next_state = HDR;
    endcase
  end

  // Pop and write strobes are purely combinational so data moves with zero
  // latency; reset gates every strobe.
  always_comb begin
    hdr_pop = 1'b0;
    xfer    = 1'b0;
    busy    = 1'b0;
    in_rden = 1'b0;
    c1_wren = 1'b0;
    c2_wren = 1'b0;
    if (!RESET) begin
      case (state)
        HDR: begin
          hdr_pop = !in_rdempty;
        end
        PAYLOAD: begin
          busy = 1'b1;
          xfer = !in_rdempty && !sel_full;
        end
        default: ;
      endcase
      in_rden = hdr_pop || xfer;
      c1_wren = xfer && !sel;
      c2_wren = xfer && sel;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      sel       <= 1'b0;
      remaining <= '0;
      c1_frames <= '0;
      c2_frames <= '0;
    end else begin
      if (hdr_pop) begin
        sel       <= hdr_sel;
        remaining <= hdr_len;
      end
      if (xfer) begin
        remaining <= remaining - REM_W'(1);
      end
      if (last_xfer) begin
        if (sel) begin
          if (c2_frames != 16'hFFFF) c2_frames <= c2_frames + 16'd1;
        end else begin
          if (c1_frames != 16'hFFFF) c1_frames <= c1_frames + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_fifo_deframe.sv
// tb_fifo_deframe
//   Drives fifo_deframe from a queue-backed source FIFO with random or scripted
//   empty gaps and sink-full flags. A stream-level model turns every consumed
//   header into a list of owed payload destinations and predicts pops, writes,
//   busy and the frame counters each cycle; directed scenarios pin the model
//   with hand-computed values.
module tb_fifo_deframe;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        in_rden;
  logic        in_rdempty;
  logic [7:0]  in_rddata;
  logic        c1_wren;
  logic        c1_wrfull;
  logic [7:0]  c1_wrdata;
  logic        c2_wren;
  logic        c2_wrfull;
  logic [7:0]  c2_wrdata;
  logic        busy;
  logic [15:0] c1_frames;
  logic [15:0] c2_frames;

  fifo_deframe #(
    .DW      (8),
    .SELMASK (8'h80),
    .CNTMASK (8'h70)
  ) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .in_rden    (in_rden),
    .in_rdempty (in_rdempty),
    .in_rddata  (in_rddata),
    .c1_wren    (c1_wren),
    .c1_wrfull  (c1_wrfull),
    .c1_wrdata  (c1_wrdata),
    .c2_wren    (c2_wren),
    .c2_wrfull  (c2_wrfull),
    .c2_wrdata  (c2_wrdata),
    .busy       (busy),
    .c1_frames  (c1_frames),
    .c2_frames  (c2_frames)
  );

  always #5 CLK = ~CLK;

  int         errors = 0;
  int         checks = 0;
  int         cyc = 0;
  logic [7:0] src_q[$];
  int         exp_q[$];
  logic [7:0] dut_c1[$];
  logic [7:0] dut_c2[$];
  int         c1_cyc[$];
  int         c2_cyc[$];
  int         hdr_cyc[$];
  bit         busy_at[int];
  int         m_c1 = 0;
  int         m_c2 = 0;
  int         gap_pct = 0;
  int         full_pct = 0;
  int         c2_hold = 0;
  bit         gap_every3 = 0;
  bit         toggle_c1 = 0;
  logic       popped = 1'b0;

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    check_val(name, 32'(act), 32'(exp));
  endtask

  // Compare the DUT against the stream model, then advance the model.
  task automatic check_output();
    int         kind;
    int         len;
    logic       full_sel;
    logic       exp_pop;
    logic [7:0] d;
    cyc++;
    kind = (exp_q.size() == 0) ? 0 : exp_q[0];
    busy_at[cyc] = busy;
    if (c1_wren) begin dut_c1.push_back(c1_wrdata); c1_cyc.push_back(cyc); end
    if (c2_wren) begin dut_c2.push_back(c2_wrdata); c2_cyc.push_back(cyc); end
    check_val("c1_frames", 32'(c1_frames), 32'(m_c1));
    check_val("c2_frames", 32'(c2_frames), 32'(m_c2));
    check_val("c1_wrdata", 32'(c1_wrdata), 32'(in_rddata));
    check_val("c2_wrdata", 32'(c2_wrdata), 32'(in_rddata));
    if (RESET) begin
      check_bit("rden_in_reset", in_rden, 1'b0);
      check_bit("c1_wren_in_reset", c1_wren, 1'b0);
      check_bit("c2_wren_in_reset", c2_wren, 1'b0);
      check_bit("busy_in_reset", busy, 1'b0);
      exp_q.delete();
      m_c1 = 0;
      m_c2 = 0;
    end else begin
      full_sel = (kind == 1) ? c1_wrfull : (kind == 2) ? c2_wrfull : 1'b0;
      exp_pop  = !in_rdempty && !full_sel;
      check_bit("in_rden", in_rden, exp_pop);
      check_bit("c1_wren", c1_wren, exp_pop && (kind == 1));
      check_bit("c2_wren", c2_wren, exp_pop && (kind == 2));
      check_bit("busy", busy, kind != 0);
      if (exp_pop) begin
        d = in_rddata;
        if (kind == 0) begin
          hdr_cyc.push_back(cyc);
          len = ((int'(d) / 16) % 8) + 1;
          for (int i = 0; i < len; i++) exp_q.push_back((d >= 8'h80) ? 2 : 1);
        end else begin
          void'(exp_q.pop_front());
          if (exp_q.size() == 0) begin
            if (kind == 1) m_c1 = (m_c1 == 65535) ? 65535 : m_c1 + 1;
            else           m_c2 = (m_c2 == 65535) ? 65535 : m_c2 + 1;
          end
        end
      end
    end
    popped = in_rden;
  endtask

  task automatic drive_inputs();
    logic gap;
    gap = gap_every3 ? (cyc % 3 != 0) : (int'($urandom_range(99)) < gap_pct);
    in_rdempty = (src_q.size() == 0) || gap;
    in_rddata  = (src_q.size() != 0) ? src_q[0] : 8'($urandom);
    if (toggle_c1) c1_wrfull = ~c1_wrfull;
    else           c1_wrfull = (int'($urandom_range(99)) < full_pct);
    if (c2_hold > 0) begin
      c2_wrfull = 1'b1;
      c2_hold--;
    end else begin
      c2_wrfull = (int'($urandom_range(99)) < full_pct);
    end
  endtask

  task automatic apply_stimulus();
    @(posedge CLK);
    #1;
    if (popped && src_q.size() > 0) void'(src_q.pop_front());
    drive_inputs();
  endtask

  task automatic step();
    @(negedge CLK);
    check_output();
    apply_stimulus();
  endtask

  task automatic start_scenario(input int gp, input int fp);
    gap_pct    = gp;
    full_pct   = fp;
    gap_every3 = 0;
    toggle_c1  = 0;
    c2_hold    = 0;
    src_q.delete();
    RESET = 1'b1;
    drive_inputs();
    step();
    step();
    RESET = 1'b0;
    dut_c1.delete();
    dut_c2.delete();
    c1_cyc.delete();
    c2_cyc.delete();
    hdr_cyc.delete();
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while ((src_q.size() != 0 || exp_q.size() != 0) && n < budget) begin
      step();
      n++;
    end
    check_bit({name, "_drained"}, (src_q.size() == 0) && (exp_q.size() == 0), 1'b1);
    step();
    step();
  endtask

  task automatic wait_writes(input string name, input bit client2, input int count);
    int n;
    n = 0;
    while ((client2 ? dut_c2.size() : dut_c1.size()) < count && n < 40) begin
      step();
      n++;
    end
    check_bit({name, "_reached"}, n < 40, 1'b1);
  endtask

  initial begin
    logic [7:0] s1_exp [3];
    logic [7:0] r1[$];
    logic [7:0] r2[$];
    logic [7:0] hdr;
    int         lowc;
    int         f1;
    int         f2;
    int         len;
    int         gps [4];
    int         fps [4];

    RESET      = 1'b1;
    in_rdempty = 1'b1;
    in_rddata  = 8'h00;
    c1_wrfull  = 1'b0;
    c2_wrfull  = 1'b0;

    // Scenario 1: one 3-word client 1 frame.
    start_scenario(0, 0);
    src_q = '{8'h20, 8'h11, 8'h22, 8'h33};
    drive_inputs();
    drain("s1", 50);
    s1_exp = '{8'h11, 8'h22, 8'h33};
    check_val("s1_c1_count", 32'(dut_c1.size()), 32'd3);
    if (dut_c1.size() == 3 && hdr_cyc.size() > 0) begin
      for (int i = 0; i < 3; i++) begin
        check_val("s1_c1_data", 32'(dut_c1[i]), 32'(s1_exp[i]));
        check_val("s1_c1_cycle", 32'(c1_cyc[i] - hdr_cyc[0]), 32'(i + 1));
      end
    end
    check_val("s1_c2_count", 32'(dut_c2.size()), 32'd0);
    check_val("s1_c1_frames", 32'(c1_frames), 32'd1);
    check_val("s1_model_c1", 32'(m_c1), 32'd1);

    // Scenario 2: two client 2 frames back to back (1 word, then 8 words).
    start_scenario(0, 0);
    src_q = '{8'h80, 8'h5A, 8'hF0};
    for (int i = 0; i < 8; i++) src_q.push_back(8'hC0 + 8'(i));
    drive_inputs();
    drain("s2", 60);
    check_val("s2_c2_count", 32'(dut_c2.size()), 32'd9);
    if (dut_c2.size() == 9) begin
      check_val("s2_c2_first", 32'(dut_c2[0]), 32'h5A);
      for (int i = 0; i < 8; i++) check_val("s2_c2_data", 32'(dut_c2[i + 1]), 32'(8'hC0 + 8'(i)));
      lowc = 0;
      for (int c = hdr_cyc[0]; c <= c2_cyc[8]; c++) if (!busy_at[c]) lowc++;
      check_val("s2_busy_low_cycles", 32'(lowc), 32'd2);
    end
    check_val("s2_c2_frames", 32'(c2_frames), 32'd2);
    check_val("s2_c1_count", 32'(dut_c1.size()), 32'd0);

    // Scenario 3: client 2 sink full for 5 cycles after word 2, c1 full toggling.
    start_scenario(0, 0);
    toggle_c1 = 1;
    src_q = '{8'hB0, 8'h31, 8'h32, 8'h33, 8'h34};
    drive_inputs();
    wait_writes("s3_two_words", 1'b1, 2);
    c2_wrfull = 1'b1;
    c2_hold   = 4;
    drain("s3", 60);
    check_val("s3_c2_count", 32'(dut_c2.size()), 32'd4);
    if (dut_c2.size() == 4) begin
      for (int i = 0; i < 4; i++) check_val("s3_c2_data", 32'(dut_c2[i]), 32'(8'h31 + 8'(i)));
      check_val("s3_stall_gap", 32'(c2_cyc[2] - c2_cyc[1]), 32'd6);
    end
    check_val("s3_c2_frames", 32'(c2_frames), 32'd1);
    check_val("s3_c1_count", 32'(dut_c1.size()), 32'd0);

    // Scenario 4: reset after word 2 of a 6-word client 1 frame.
    start_scenario(0, 0);
    src_q = '{8'h50, 8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46};
    drive_inputs();
    wait_writes("s4_two_words", 1'b0, 2);
    RESET = 1'b1;
    src_q.delete();
    drive_inputs();
    step();
    step();
    RESET = 1'b0;
    src_q = '{8'h80, 8'h7E};
    drive_inputs();
    drain("s4", 40);
    check_val("s4_c1_count", 32'(dut_c1.size()), 32'd2);
    check_val("s4_c2_count", 32'(dut_c2.size()), 32'd1);
    if (dut_c2.size() == 1) check_val("s4_c2_data", 32'(dut_c2[0]), 32'h7E);
    check_val("s4_c1_frames", 32'(c1_frames), 32'd0);
    check_val("s4_c2_frames", 32'(c2_frames), 32'd1);

    // Scenario 5: client 1 counter near the top, then saturate.
    start_scenario(0, 0);
    force dut.c1_frames = 16'hFFFD;
    #1;
    release dut.c1_frames;
    m_c1 = 65533;
    for (int i = 0; i < 4; i++) begin
      src_q.push_back(8'h00);
      src_q.push_back(8'h90 + 8'(i));
    end
    drive_inputs();
    drain("s5", 40);
    check_val("s5_c1_frames", 32'(c1_frames), 32'hFFFF);
    check_val("s5_model_c1", 32'(m_c1), 32'd65535);
    check_val("s5_c2_frames", 32'(c2_frames), 32'd0);

    // Scenario 6: source delivers a word only every third cycle.
    start_scenario(0, 0);
    gap_every3 = 1;
    src_q = '{8'h20, 8'hA1, 8'hA2, 8'hA3, 8'h85, 8'hD1, 8'h10, 8'hE1, 8'hE2};
    drive_inputs();
    drain("s6", 200);
    check_val("s6_c1_count", 32'(dut_c1.size()), 32'd5);
    check_val("s6_c2_count", 32'(dut_c2.size()), 32'd1);
    if (dut_c2.size() == 1) check_val("s6_c2_data", 32'(dut_c2[0]), 32'hD1);
    check_val("s6_c1_frames", 32'(c1_frames), 32'd2);
    check_val("s6_c2_frames", 32'(c2_frames), 32'd1);

    // Random batches with varying gap and back-pressure rates.
    gps = '{0, 30, 60, 20};
    fps = '{0, 20, 50, 70};
    for (int b = 0; b < 4; b++) begin
      start_scenario(gps[b], fps[b]);
      r1.delete();
      r2.delete();
      f1 = 0;
      f2 = 0;
      for (int f = 0; f < 40; f++) begin
        hdr = 8'($urandom);
        src_q.push_back(hdr);
        len = ((int'(hdr) / 16) % 8) + 1;
        for (int i = 0; i < len; i++) begin
          logic [7:0] w;
          w = 8'($urandom);
          src_q.push_back(w);
          if (hdr >= 8'h80) r2.push_back(w);
          else              r1.push_back(w);
        end
        if (hdr >= 8'h80) f2++;
        else              f1++;
      end
      drive_inputs();
      drain("rand", 8000);
      check_val("rand_c1_count", 32'(dut_c1.size()), 32'(r1.size()));
      check_val("rand_c2_count", 32'(dut_c2.size()), 32'(r2.size()));
      if (dut_c1.size() == r1.size())
        for (int i = 0; i < r1.size(); i++) check_val("rand_c1_data", 32'(dut_c1[i]), 32'(r1[i]));
      if (dut_c2.size() == r2.size())
        for (int i = 0; i < r2.size(); i++) check_val("rand_c2_data", 32'(dut_c2[i]), 32'(r2[i]));
      check_val("rand_c1_frames", 32'(c1_frames), 32'(f1));
      check_val("rand_c2_frames", 32'(c2_frames), 32'(f2));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

endmodule
